// File: rtl/tdm_demux4.sv
// Receive side of a 4-channel TDM link: steers serial samples into slots 0..3 using
// a sync-aligned round-robin counter and publishes each complete frame on a..d.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             s1,
  output logic             s2,
  output logic             locked,
  output logic             frame_valid,
  output logic             sync_err
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state;
  logic [1:0]       slot;
  logic [WIDTH-1:0] shadow0, shadow1, shadow2;

  // Handshake: a sample is consumed on every rising edge where din_valid=1; there is
  // no back-pressure. sync is meaningful only on those edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      slot        <= 2'd0;
      shadow0     <= '0;
      shadow1     <= '0;
      shadow2     <= '0;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        case (state)
          HUNT: begin
            if (sync) begin
              shadow0 <= din;
              slot    <= 2'd1;
              state   <= LOCKED;
            end
          end
          LOCKED: begin
            if (sync && slot != 2'd0) begin
              // Sync mid-frame: drop the partial frame and realign on this sample.
              sync_err <= 1'b1;
              shadow0  <= din;
              slot     <= 2'd1;
            end else begin
              case (slot)
                2'd0: shadow0 <= din;
                2'd1: shadow1 <= din;
                2'd2: shadow2 <= din;
                default: begin
                  // Slot 3 goes straight to d so the frame lands one edge after it.
                  a           <= shadow0;
                  b           <= shadow1;
                  c           <= shadow2;
                  d           <= din;
                  frame_valid <= 1'b1;
                end
              endcase
              slot <= slot + 2'd1;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign s1     = slot[1];
  assign s2     = slot[0];
  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: hunt, lock, gaps, resync, async reset and streaming.
module tb_tdm_demux4;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         sync = 1'b0;
  logic [W-1:0] a, b, c, d;
  logic         s1, s2, locked, frame_valid, sync_err;

  int checks = 0;
  int failures = 0;

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .a(a), .b(b), .c(c), .d(d), .s1(s1), .s2(s2),
    .locked(locked), .frame_valid(frame_valid), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Present one input cycle, then settle 1 ns past the capturing edge.
  task automatic drive(input logic v, input logic s, input logic [W-1:0] x);
    din_valid = v;
    sync      = s;
    din       = x;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    sync      = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if ({a, b, c, d} !== '0) begin failures++; $display("FAIL reset_abcd got=%h exp=0", {a, b, c, d}); end
    checks++; if ({s1, s2, locked, frame_valid, sync_err} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {s1, s2, locked, frame_valid, sync_err}); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_hunt();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'h01);
      checks++; if ({locked, s1, s2, frame_valid} !== 4'b0000) begin failures++; $display("FAIL hunt_flags[%0d] got=%b exp=0000", i, {locked, s1, s2, frame_valid}); end
    end
    checks++; if ({a, b, c, d} !== '0) begin failures++; $display("FAIL hunt_abcd got=%h exp=0", {a, b, c, d}); end
  endtask

  task automatic test_lock_frame();
    drive(1'b1, 1'b1, 8'h01);
    checks++; if ({locked, s1, s2, frame_valid} !== 4'b1010) begin failures++; $display("FAIL lock_first got=%b exp=1010", {locked, s1, s2, frame_valid}); end
    drive(1'b1, 1'b0, 8'h00);
    checks++; if ({s1, s2} !== 2'b10) begin failures++; $display("FAIL lock_slot2 got=%b exp=10", {s1, s2}); end
    drive(1'b1, 1'b0, 8'h00);
    checks++; if ({s1, s2, frame_valid} !== 3'b110) begin failures++; $display("FAIL lock_slot3 got=%b exp=110", {s1, s2, frame_valid}); end
    drive(1'b1, 1'b0, 8'h01);
    checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL lock_fv got=%b exp=1", frame_valid); end
    checks++; if ({a, b, c, d} !== 32'h01000001) begin failures++; $display("FAIL lock_abcd got=%h exp=01000001", {a, b, c, d}); end
    checks++; if ({s1, s2} !== 2'b00) begin failures++; $display("FAIL lock_wrap got=%b exp=00", {s1, s2}); end
    drive(1'b0, 1'b0, 8'h00);
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL lock_fv_pulse got=%b exp=0", frame_valid); end
    checks++; if (a !== 8'h01) begin failures++; $display("FAIL lock_hold got=%h exp=01", a); end
  endtask

  task automatic test_gapped();
    logic [W-1:0] vals [4];
    logic [1:0]   slot_exp;
    vals[0] = 8'h01; vals[1] = 8'h00; vals[2] = 8'h00; vals[3] = 8'h01;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0), vals[i]);
      slot_exp = 2'(i + 1);
      if (i < 3) begin
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL gap_early_fv[%0d] got=%b exp=0", i, frame_valid); end
        drive(1'b0, 1'b1, 8'hff);
        checks++; if ({s1, s2, frame_valid} !== {slot_exp, 1'b0}) begin failures++; $display("FAIL gap_hold[%0d] got=%b exp=%b0", i, {s1, s2, frame_valid}, slot_exp); end
      end
    end
    checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL gap_fv got=%b exp=1", frame_valid); end
    checks++; if ({a, b, c, d} !== 32'h01000001) begin failures++; $display("FAIL gap_abcd got=%h exp=01000001", {a, b, c, d}); end
  endtask

  task automatic test_resync();
    drive(1'b1, 1'b1, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h01);
    checks++; if ({sync_err, frame_valid, s1, s2} !== 4'b1001) begin failures++; $display("FAIL resync_flags got=%b exp=1001", {sync_err, frame_valid, s1, s2}); end
    checks++; if ({a, b, c, d} !== 32'h01000001) begin failures++; $display("FAIL resync_abcd got=%h exp=01000001", {a, b, c, d}); end
    drive(1'b1, 1'b0, 8'h00);
    checks++; if (sync_err !== 1'b0) begin failures++; $display("FAIL resync_pulse got=%b exp=0", sync_err); end
    drive(1'b1, 1'b0, 8'h01);
    drive(1'b1, 1'b0, 8'h00);
    checks++; if (frame_valid !== 1'b1) begin failures++; $display("FAIL resync_fv got=%b exp=1", frame_valid); end
    checks++; if ({a, b, c, d} !== 32'h01000100) begin failures++; $display("FAIL resync_abcd2 got=%h exp=01000100", {a, b, c, d}); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b1, 8'h05);
    drive(1'b1, 1'b0, 8'h06);
    drive(1'b1, 1'b0, 8'h07);
    checks++; if ({locked, s1, s2} !== 3'b111) begin failures++; $display("FAIL arst_pre got=%b exp=111", {locked, s1, s2}); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({a, b, c, d} !== '0) begin failures++; $display("FAIL arst_abcd got=%h exp=0", {a, b, c, d}); end
    checks++; if ({locked, s1, s2, frame_valid, sync_err} !== 5'b0) begin failures++; $display("FAIL arst_flags got=%b exp=00000", {locked, s1, s2, frame_valid, sync_err}); end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 8'h08);
    checks++; if ({frame_valid, locked, d} !== 10'b0) begin failures++; $display("FAIL arst_noframe got=%b/%b/%h exp=0/0/00", frame_valid, locked, d); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_q [$];
    logic [4*W-1:0] exp_frame;
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < 4; s++) exp_q.push_back(8'((f + 1) * 16 + s + 1));
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, (i == 0), exp_q[i]);
      checks++; if (frame_valid !== (i % 4 == 3)) begin failures++; $display("FAIL stream_fv[%0d] got=%b exp=%b", i, frame_valid, (i % 4 == 3)); end
      if (i % 4 == 3) begin
        exp_frame = {exp_q[i-3], exp_q[i-2], exp_q[i-1], exp_q[i]};
        checks++; if ({a, b, c, d} !== exp_frame) begin failures++; $display("FAIL stream_abcd[%0d] got=%h exp=%h", i / 4, {a, b, c, d}, exp_frame); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_hunt();
    test_lock_frame();
    test_gapped();
    test_resync();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Time-division demultiplexer: the receive end of a 4-channel TDM link whose transmit end is the 4:1 mux selected by {s1,s2}.
- Accepts one serial sample per valid cycle and steers it to channel slot 0..3 using an internal round-robin slot counter aligned by a frame sync marker.
- Presents a complete frame on four registered parallel outputs a, b, c, d, with a one-cycle frame strobe.
- Sits after the serial link, before per-channel consumers.

Parameters:
- WIDTH, 1, sample width in bits for din and each of a/b/c/d.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- din  input  WIDTH  serial sample.
- din_valid  input  1  din carries a sample this cycle.
- sync  input  1  qualified by din_valid; marks the current sample as slot 0.
- a  output  WIDTH  channel 0 (slot 0) sample of last complete frame.
- b  output  WIDTH  channel 1 (slot 1) sample of last complete frame.
- c  output  WIDTH  channel 2 (slot 2) sample of last complete frame.
- d  output  WIDTH  channel 3 (slot 3) sample of last complete frame.
- s1  output  1  slot counter MSB.
- s2  output  1  slot counter LSB ({s1,s2} = slot the next accepted sample goes to).
- locked  output  1  frame alignment acquired.
- frame_valid  output  1  one-cycle pulse: a..d just updated with a new frame.
- sync_err  output  1  one-cycle pulse: sync arrived mid-frame.

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous, active-high.
- Reset values (async, immediate): slot=0, shadow regs 0..2 = 0, a=b=c=d=0, locked=0, frame_valid=0, sync_err=0.
- Reset mid-frame discards the partial frame and returns to HUNT. a..d are cleared.
- HUNT state (locked=0):
  - Samples with din_valid=1, sync=0 are discarded; slot stays 0.
  - din_valid=1 with sync=1: store din into shadow0, slot<=1, go to LOCKED.
- LOCKED state (locked=1), on each din_valid=1:
  - sync=0 or slot==0: store din into shadow[slot], slot<=slot+1 mod 4.
  - slot==3 accept: a<=shadow0, b<=shadow1, c<=shadow2, d<=din (the current sample, not a shadow reg), all in the same edge. frame_valid=1 for exactly the following cycle. slot wraps to 0.
  - sync=1 with slot!=0: sync_err=1 for the following cycle. Partial frame discarded (a..d unchanged, no frame_valid). din stored into shadow0, slot<=1. Stay LOCKED.
  - sync=1 with slot==0: normal slot-0 accept, no error.
- After lock, sync is optional; the counter free-runs round-robin on valid samples.
- din_valid=0: no state change. sync is ignored. frame_valid and sync_err are 0.
- Latency: the frame appears on a..d one clock after the slot-3 sample is presented.
- a..d hold their value between frames.
- Pulses are never asserted in HUNT.
- Throughput: one sample per cycle sustained. Back-to-back frames give frame_valid every 4th cycle.
- {s1,s2} is a registered copy of slot. It reads 00 in HUNT.
- Outputs are registered only; no combinational path from din to a..d.

Test Plan:
- Reset, then din_valid=1 with sync=0 for 3 cycles -> locked=0, {s1,s2}=00, a..d=0, no frame_valid.
- Lock and full frame: sync+din=1, then 0,0,1 (WIDTH=1) on consecutive valid cycles -> locked=1 after the first edge. The cycle after the 4th sample: a=1, b=0, c=0, d=1, frame_valid=1 for one cycle.
- Gapped input: same frame with din_valid=0 cycles interleaved -> identical a..d. frame_valid only after the 4th valid sample. {s1,s2} holds during gaps.
- Mid-frame resync: lock, send 2 samples, then sync+din=1 -> sync_err=1 for one cycle, {s1,s2}=01, a..d unchanged. Three more samples complete a frame with a=1.
- Async reset after 3 samples in LOCKED -> outputs clear immediately (before the next clk edge), locked=0. A subsequent slot-3-style sample without sync produces no frame.
- Sustained streaming: WIDTH=8, 3 back-to-back frames (0x11..0x14, 0x21..0x24, 0x31..0x34) -> frame_valid every 4th cycle. a..d = 0x11..0x14, then 0x21..0x24, then 0x31..0x34.
